// File: rtl/mealy_6_pkg.sv
// mealy_6_pkg: shared state encoding and target pattern for the 1010 detector
package mealy_6_pkg;
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;
  localparam logic [3:0] PATTERN = 4'b1010;
endpackage

// File: rtl/mealy_6.sv
// mealy_6: Mealy detector for serial 1010, optional overlapping matches
module mealy_6
  import mealy_6_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y
);
  state_t state, nxt;
  // state register, sync reset discards any partial match
  always_ff @(posedge clk)
    state <= rst ? S0 : nxt;
  // next state and detect flag; in S3 "101" is held, so x equal to the last pattern bit completes a match
  always_comb begin
    nxt = S0;
    case (state)
      S0: nxt = x ? S1 : S0;
      S1: nxt = x ? S1 : S2;
      S2: nxt = x ? S3 : S0;
      S3: nxt = x ? S1 : (OVERLAP ? S2 : S0);
      default: nxt = S0;
    endcase
    y = !rst && state == S3 && x == PATTERN[0];
  end
endmodule

// File: tb/tb_mealy_6.sv
// tb_mealy_6: directed checks of the 1010 detector in overlapping and non-overlapping builds
module tb_mealy_6;
  import mealy_6_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x = 1'b0;
  logic y1, y0;
  int checks = 0;
  int errors = 0;

  mealy_6 #(.OVERLAP(1'b1)) u1 (.clk(clk), .rst(rst), .x(x), .y(y1));
  mealy_6 #(.OVERLAP(1'b0)) u0 (.clk(clk), .rst(rst), .x(x), .y(y0));

  always #5 clk = ~clk;

  // present one bit for a full cycle, settle just after the falling edge
  task automatic drive(input logic xi, input logic ri);
    @(negedge clk);
    x = xi;
    rst = ri;
    #1;
  endtask

  task automatic do_reset;
    drive(1'b0, 1'b1);
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1);
    checks += 2;
    if (y1 !== 1'b0) begin errors++; $display("FAIL reset_c1 y1 got %b exp 0", y1); end
    if (y0 !== 1'b0) begin errors++; $display("FAIL reset_c1 y0 got %b exp 0", y0); end
    drive(1'b0, 1'b1);
    checks += 4;
    if (u1.state !== S0) begin errors++; $display("FAIL reset_state u1 got %b exp 00", u1.state); end
    if (u0.state !== S0) begin errors++; $display("FAIL reset_state u0 got %b exp 00", u0.state); end
    if (y1 !== 1'b0) begin errors++; $display("FAIL reset_c2 y1 got %b exp 0", y1); end
    if (y0 !== 1'b0) begin errors++; $display("FAIL reset_c2 y0 got %b exp 0", y0); end
  endtask

  task automatic test_single;
    logic [3:0] xs = 4'b1010;
    logic [3:0] ex = 4'b0001;
    do_reset;
    for (int i = 3; i >= 0; i--) begin
      drive(xs[i], 1'b0);
      checks += 2;
      if (y1 !== ex[i]) begin errors++; $display("FAIL single bit%0d y1 got %b exp %b", 4 - i, y1, ex[i]); end
      if (y0 !== ex[i]) begin errors++; $display("FAIL single bit%0d y0 got %b exp %b", 4 - i, y0, ex[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] xs = 8'b10101010;
    logic [7:0] e1 = 8'b00010101;
    logic [7:0] e0 = 8'b00010001;
    do_reset;
    for (int i = 7; i >= 0; i--) begin
      drive(xs[i], 1'b0);
      checks += 2;
      if (y1 !== e1[i]) begin errors++; $display("FAIL overlap bit%0d y1 got %b exp %b", 8 - i, y1, e1[i]); end
      if (y0 !== e0[i]) begin errors++; $display("FAIL nonoverlap bit%0d y0 got %b exp %b", 8 - i, y0, e0[i]); end
    end
  endtask

  task automatic test_near_miss;
    logic [13:0] xs = 14'b1101100_1001010;
    logic [13:0] ex = 14'b0000000_0000001;
    do_reset;
    for (int i = 13; i >= 0; i--) begin
      drive(xs[i], 1'b0);
      checks += 2;
      if (y1 !== ex[i]) begin errors++; $display("FAIL near_miss bit%0d y1 got %b exp %b", 14 - i, y1, ex[i]); end
      if (y0 !== ex[i]) begin errors++; $display("FAIL near_miss bit%0d y0 got %b exp %b", 14 - i, y0, ex[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] xs = 9'b101_0_0_1010;
    logic [8:0] rs = 9'b000_1_0_0000;
    logic [8:0] ex = 9'b000_0_0_0001;
    do_reset;
    for (int i = 8; i >= 0; i--) begin
      drive(xs[i], rs[i]);
      checks += 2;
      if (y1 !== ex[i]) begin errors++; $display("FAIL reset_mid step%0d y1 got %b exp %b", 9 - i, y1, ex[i]); end
      if (y0 !== ex[i]) begin errors++; $display("FAIL reset_mid step%0d y0 got %b exp %b", 9 - i, y0, ex[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_near_miss;
    test_reset_mid;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
